// File: rtl/serial_link_axi_to_obi_bridge.sv
// AXI4 subordinate terminating the serial link's outbound AXI port; every burst is
// replayed as single-word OBI manager accesses, one transaction and one access at a time.
package serial_link_axi_to_obi_bridge_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;
  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;
  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module serial_link_axi_to_obi_bridge #(
  parameter type axi_req_t  = serial_link_axi_to_obi_bridge_pkg::axi_req_t,
  parameter type axi_rsp_t  = serial_link_axi_to_obi_bridge_pkg::axi_rsp_t,
  parameter type obi_req_t  = serial_link_axi_to_obi_bridge_pkg::obi_req_t,
  parameter type obi_resp_t = serial_link_axi_to_obi_bridge_pkg::obi_resp_t,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  axi_req_i,
  output axi_rsp_t  axi_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_rsp_i,
  output logic      busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(StrbWidth - 1);
  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] BurstWrap = 2'b10;

  typedef enum logic [2:0] {
    IDLE, W_BEAT, W_REQ, W_WAIT, B_RESP, R_REQ, R_WAIT, R_DATA
  } state_e;

  state_e                 state_q;
  logic                   prioRead_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             len_q;
  logic [7:0]             beat_q;
  logic [1:0]             burst_q;
  logic [IdWidth-1:0]     id_q;
  logic                   err_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   strb_q;
  logic [DataWidth-1:0]   rdata_q;

  logic                   grantWrite;
  logic                   grantRead;
  logic                   lastBeat;
  logic [AddrWidth-1:0]   addr_d;
  logic                   unusedSize;

  assign grantWrite = axi_req_i.aw_valid & (~axi_req_i.ar_valid | ~prioRead_q);
  assign grantRead  = axi_req_i.ar_valid & (~axi_req_i.aw_valid | prioRead_q);
  assign lastBeat   = (beat_q == len_q);
  assign addr_d     = (burst_q == BurstIncr) ? addr_q + AddrWidth'(StrbWidth) : addr_q;
  assign busy_o     = (state_q != IDLE);
  assign unusedSize = ^{axi_req_i.aw.size, axi_req_i.ar.size};

  // Erroneous (WRAP) bursts bypass OBI entirely but still walk the beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      prioRead_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantWrite) begin
            prioRead_q <= ~prioRead_q;
            addr_q     <= axi_req_i.aw.addr & ~AlignMask;
            len_q      <= axi_req_i.aw.len;
            burst_q    <= axi_req_i.aw.burst;
            id_q       <= axi_req_i.aw.id;
            beat_q     <= '0;
            err_q      <= (axi_req_i.aw.burst == BurstWrap);
            state_q    <= W_BEAT;
          end else if (grantRead) begin
            prioRead_q <= ~prioRead_q;
            addr_q     <= axi_req_i.ar.addr & ~AlignMask;
            len_q      <= axi_req_i.ar.len;
            burst_q    <= axi_req_i.ar.burst;
            id_q       <= axi_req_i.ar.id;
            beat_q     <= '0;
            err_q      <= (axi_req_i.ar.burst == BurstWrap);
            rdata_q    <= '0;
            state_q    <= (axi_req_i.ar.burst == BurstWrap) ? R_DATA : R_REQ;
          end
        end
        W_BEAT: begin
          if (axi_req_i.w_valid) begin
            wdata_q <= axi_req_i.w.data;
            strb_q  <= axi_req_i.w.strb;
            if (axi_req_i.w.last != lastBeat) err_q <= 1'b1;
            if (!err_q) begin
              state_q <= W_REQ;
            end else if (lastBeat) begin
              state_q <= B_RESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        W_REQ: if (obi_rsp_i.gnt) state_q <= W_WAIT;
        W_WAIT: begin
          if (obi_rsp_i.rvalid) begin
            if (lastBeat) begin
              state_q <= B_RESP;
            end else begin
              beat_q  <= beat_q + 8'd1;
              addr_q  <= addr_d;
              state_q <= W_BEAT;
            end
          end
        end
        B_RESP: if (axi_req_i.b_ready) state_q <= IDLE;
        R_REQ: if (obi_rsp_i.gnt) state_q <= R_WAIT;
        R_WAIT: begin
          if (obi_rsp_i.rvalid) begin
            rdata_q <= obi_rsp_i.rdata;
            state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_req_i.r_ready) begin
            if (lastBeat) begin
              state_q <= IDLE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              addr_q  <= addr_d;
              state_q <= err_q ? R_DATA : R_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_rsp_o = '0;
    obi_req_o = '0;
    axi_rsp_o.aw_ready = (state_q == IDLE) & grantWrite;
    axi_rsp_o.ar_ready = (state_q == IDLE) & grantRead;
    axi_rsp_o.w_ready  = (state_q == W_BEAT);
    axi_rsp_o.b_valid  = (state_q == B_RESP);
    axi_rsp_o.b.id     = id_q;
    axi_rsp_o.b.resp   = {err_q, 1'b0};
    axi_rsp_o.r_valid  = (state_q == R_DATA);
    axi_rsp_o.r.id     = id_q;
    axi_rsp_o.r.data   = rdata_q;
    axi_rsp_o.r.resp   = {err_q, 1'b0};
    axi_rsp_o.r.last   = lastBeat;
    obi_req_o.req      = (state_q == W_REQ) | (state_q == R_REQ);
    obi_req_o.we       = (state_q == W_REQ);
    obi_req_o.be       = (state_q == W_REQ) ? strb_q : {StrbWidth{1'b1}};
    obi_req_o.addr     = addr_q;
    obi_req_o.wdata    = wdata_q;
  end

endmodule
